// File: rtl/bus_drive_sequencer.sv
// rtl/bus_drive_sequencer.sv - round-robin owner of the tristate bus enables with dead-cycle turnaround
module bus_drive_sequencer #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int BURST = 4,
  parameter int DEAD  = 1,
  localparam int IW   = (N > 1) ? $clog2(N) : 1,
  localparam int DW   = (DEAD > 1) ? $clog2(DEAD + 1) : 1,
  localparam int BW   = (BURST > 1) ? $clog2(BURST + 1) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic [W-1:0]  bus_in_i,
  output logic [N-1:0]  en_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          busy_o,
  output logic [W-1:0]  data_out_o,
  output logic          data_valid_o,
  output logic [IW-1:0] data_src_o
);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_t;

  localparam logic [IW:0]   N_V        = (IW + 1)'(N);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  state_t        state_q;
  logic [N-1:0]  en_q;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] ptr_q;
  logic          busy_q;
  logic [W-1:0]  data_q;
  logic          valid_q;
  logic [IW-1:0] src_q;
  logic [DW-1:0] dead_q;
  logic [BW-1:0] beat_q;

  logic [IW-1:0] next_ptr_d;
  logic [IW-1:0] base_d;
  logic [IW:0]   sum_d;
  logic          win_found_d;
  logic [IW-1:0] win_idx_d;

  // At a DRIVE exit the new winner is searched from the pointer being written this edge.
  always_comb begin
    next_ptr_d  = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
    base_d      = (state_q == DRIVE) ? next_ptr_d : ptr_q;
    sum_d       = '0;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum_d = {1'b0, base_d} + (IW + 1)'(k);
      if (sum_d >= N_V) sum_d = sum_d - N_V;
      if (req_i[sum_d[IW-1:0]]) begin
        win_found_d = 1'b1;
        win_idx_d   = sum_d[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      en_q    <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      dead_q  <= '0;
      beat_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          en_q <= '0;
          if (win_found_d) begin
            gnt_q   <= win_idx_d;
            dead_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= TURN;
          end
        end
        TURN: begin
          if (dead_q == DEAD_LAST) begin
            if (req_i[gnt_q]) begin
              en_q    <= N'(1) << gnt_q;
              beat_q  <= '0;
              state_q <= DRIVE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            dead_q <= dead_q + 1'b1;
          end
        end
        DRIVE: begin
          if (req_i[gnt_q]) begin
            data_q  <= bus_in_i;
            src_q   <= gnt_q;
            valid_q <= 1'b1;
            beat_q  <= beat_q + 1'b1;
          end
          if (!req_i[gnt_q] || beat_q == BURST_LAST) begin
            en_q  <= '0;
            ptr_q <= next_ptr_d;
            if (win_found_d) begin
              gnt_q   <= win_idx_d;
              dead_q  <= '0;
              state_q <= TURN;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          en_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign en_o         = en_q;
  assign gnt_idx_o    = gnt_q;
  assign busy_o       = busy_q;
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign data_src_o   = src_q;

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// tb/tb_bus_drive_sequencer.sv - directed bench for bus_drive_sequencer plus a DEAD=2 contention run
module tb_bus_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req2;
  logic [7:0] bus, bus2;
  logic [3:0] en, en2;
  logic [1:0] gnt, gnt2, src, src2;
  logic       busy, busy2, dv, dv2;
  logic [7:0] dout, dout2;

  int total = 0;
  int passed = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bus_drive_sequencer #(.N(4), .W(8), .BURST(4), .DEAD(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .bus_in_i(bus),
    .en_o(en), .gnt_idx_o(gnt), .busy_o(busy),
    .data_out_o(dout), .data_valid_o(dv), .data_src_o(src)
  );

  bus_drive_sequencer #(.N(4), .W(8), .BURST(3), .DEAD(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .bus_in_i(bus2),
    .en_o(en2), .gnt_idx_o(gnt2), .busy_o(busy2),
    .data_out_o(dout2), .data_valid_o(dv2), .data_src_o(src2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int g;
    int zrun;
    int dv_cnt;
    logic seen_nz;
    logic ok;
    logic [3:0] prev;

    rst = 1'b1; req = '0; bus = '0; req2 = '0; bus2 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_en", 32'(en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_dv", 32'(dv), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_src", 32'(src), 0);

    // single requester held: TURN, 4 beats, TURN, drive again
    req = 4'b0100;
    tick();
    chk("single_busy", 32'(busy), 1);
    chk("single_turn_en", 32'(en), 0);
    chk("single_gnt", 32'(gnt), 2);
    tick();
    chk("single_en", 32'(en), 4);
    chk("single_dv0", 32'(dv), 0);
    for (int b = 0; b < 4; b++) begin
      bus = 8'(8'h20 + b);
      tick();
      chk("single_dv", 32'(dv), 1);
      chk("single_data", 32'(dout), 32'(8'h20 + b));
      chk("single_src", 32'(src), 2);
      chk("single_en_beat", 32'(en), (b < 3) ? 4 : 0);
    end
    chk("single_return_busy", 32'(busy), 1);
    chk("single_return_gnt", 32'(gnt), 2);
    tick();
    chk("single_regrant_en", 32'(en), 4);

    // reset while driving
    rst = 1'b1; bus = 8'hFF;
    tick();
    chk("mid_rst_en", 32'(en), 0);
    chk("mid_rst_dv", 32'(dv), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_dout", 32'(dout), 0);
    tick();
    rst = 1'b0; req = '0;
    tick();
    chk("post_rst_dv", 32'(dv), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // round robin with all requesting
    req = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      g = i % 4;
      chk("rr_gnt", 32'(gnt), 32'(g));
      chk("rr_turn_en", 32'(en), 0);
      tick();
      chk("rr_en", 32'(en), 32'(1 << g));
      for (int b = 0; b < 4; b++) begin
        bus = 8'(16 * g + b);
        tick();
        chk("rr_dv", 32'(dv), 1);
        chk("rr_src", 32'(src), 32'(g));
        chk("rr_data", 32'(dout), 32'(16 * g + b));
      end
      chk("rr_exit_en", 32'(en), 0);
    end
    req = '0;
    tick();
    chk("rr_idle_busy", 32'(busy), 0);
    chk("rr_idle_en", 32'(en), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // early release after two beats
    req = 4'b0010;
    tick();
    chk("early_busy", 32'(busy), 1);
    chk("early_gnt", 32'(gnt), 1);
    tick();
    chk("early_en0", 32'(en), 2);
    bus = 8'h55;
    tick();
    chk("early_dv1", 32'(dv), 1);
    chk("early_data1", 32'(dout), 32'h55);
    chk("early_en1", 32'(en), 2);
    bus = 8'h66;
    tick();
    chk("early_dv2", 32'(dv), 1);
    chk("early_data2", 32'(dout), 32'h66);
    chk("early_en2", 32'(en), 2);
    req = '0; bus = 8'h77;
    tick();
    chk("early_drop_en", 32'(en), 0);
    chk("early_drop_dv", 32'(dv), 0);
    chk("early_drop_busy", 32'(busy), 0);
    chk("early_hold_data", 32'(dout), 32'h66);
    tick();
    chk("early_idle_dv", 32'(dv), 0);
    chk("early_idle_en", 32'(en), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // requests withdrawn during TURN leave the pointer alone
    req = 4'b1000;
    tick();
    chk("drop3_busy", 32'(busy), 1);
    chk("drop3_gnt", 32'(gnt), 3);
    req = '0;
    tick();
    chk("drop3_idle", 32'(busy), 0);
    chk("drop3_en", 32'(en), 0);
    req = 4'b0100;
    tick();
    chk("drop2_gnt", 32'(gnt), 2);
    req = '0;
    tick();
    chk("drop2_idle", 32'(busy), 0);
    chk("drop2_en", 32'(en), 0);
    req = 4'b1010;
    tick();
    chk("ptr_kept_gnt", 32'(gnt), 1);
    tick();
    chk("ptr_kept_en", 32'(en), 2);
    req = '0;
    tick();
    chk("ptr_kept_exit_en", 32'(en), 0);
    chk("ptr_kept_exit_busy", 32'(busy), 0);

    // DEAD=2 instance under random requests
    zrun = 0; dv_cnt = 0; seen_nz = 1'b0; prev = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req2 = 4'($urandom);
      bus2 = 8'($urandom);
      tick();
      ok = ($countones(en2) <= 1);
      if (en2 != '0 && prev != '0 && en2 != prev) ok = 1'b0;
      if (en2 != '0 && prev == '0 && seen_nz && zrun < 2) ok = 1'b0;
      chk("contention", 32'(ok), 1);
      if (dv2) dv_cnt++;
      if (en2 == '0) zrun++;
      else begin
        zrun = 0;
        seen_nz = 1'b1;
      end
      prev = en2;
    end
    chk("dut2_activity", 32'(dv_cnt > 0), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
